uart_cmd_responder: RTL and testbench

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

---
 rtl/uart_cmd_responder_if.sv | 20 ++
 rtl/uart_cmd_responder.sv | 127 ++++++++++++
 tb/tb_uart_cmd_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_responder_if.sv
// Byte-stream handshake bundle between a UART front end and the command responder.
// Both directions use valid/ready; a byte moves on a rising edge with both high.
interface uart_cmd_responder_if;
   logic [7:0] uart_rd_data;
   logic       uart_rd_valid;
   logic       uart_rd_ready;
   logic [7:0] uart_wr_data;
   logic       uart_wr_valid;
   logic       uart_wr_ready;

   modport slave (
      input  uart_rd_data, uart_rd_valid, uart_wr_ready,
      output uart_rd_ready, uart_wr_data, uart_wr_valid
   );

   modport master (
      output uart_rd_data, uart_rd_valid, uart_wr_ready,
      input  uart_rd_ready, uart_wr_data, uart_wr_valid
   );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART command responder: 'R' addr reads and 'W' addr data writes a 16x8 register file,
// answering one byte per frame; bad frames answer '?' and bump a saturating error count.
module uart_cmd_responder #(
   parameter int unsigned   TIMEOUT_CYCLES = 1000000,
   parameter logic [127:0]  RESET_VALUE    = 128'h0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_cmd_responder_if.slave   uart,
   output logic [127:0]          regs,
   output logic [7:0]            err_count
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h3F;

   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND} state_t;

   state_t           state;
   logic             op_wr;
   logic             bad_op;
   logic [7:0]       addr;
   logic [7:0]       data;
   logic [CNT_W-1:0] idle_cnt;
   logic             accept;

   assign accept = uart.uart_rd_valid && uart.uart_rd_ready;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Frame sequencer; all outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         uart.uart_rd_ready <= 1'b0;
         uart.uart_wr_valid <= 1'b0;
         uart.uart_wr_data  <= 8'h00;
         regs               <= RESET_VALUE;
         err_count          <= 8'h00;
         idle_cnt           <= '0;
         op_wr              <= 1'b0;
         bad_op             <= 1'b0;
         addr               <= 8'h00;
         data               <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               uart.uart_rd_ready <= 1'b1;
               idle_cnt           <= '0;
               if (accept) begin
                  if (uart.uart_rd_data == OP_RD || uart.uart_rd_data == OP_WR) begin
                     op_wr  <= (uart.uart_rd_data == OP_WR);
                     bad_op <= 1'b0;
                     state  <= GET_ADDR;
                  end else begin
                     bad_op             <= 1'b1;
                     uart.uart_wr_data  <= RSP_ERR;
                     uart.uart_rd_ready <= 1'b0;
                     state              <= EXEC;
                  end
               end
            end

            GET_ADDR, GET_DATA: begin
               // An accepted byte wins over a timeout landing on the same edge.
               if (accept) begin
                  idle_cnt <= '0;
                  if (state == GET_ADDR) begin
                     addr <= uart.uart_rd_data;
                     if (op_wr) begin
                        state <= GET_DATA;
                     end else begin
                        uart.uart_rd_ready <= 1'b0;
                        state              <= EXEC;
                     end
                  end else begin
                     data               <= uart.uart_rd_data;
                     uart.uart_rd_ready <= 1'b0;
                     state              <= EXEC;
                  end
               end else if (idle_cnt == CNT_LAST) begin
                  idle_cnt  <= '0;
                  err_count <= sat_inc(err_count);
                  state     <= IDLE;
               end else begin
                  idle_cnt <= idle_cnt + CNT_W'(1);
               end
            end

            EXEC: begin
               uart.uart_wr_valid <= 1'b1;
               state              <= SEND;
               if (bad_op || addr[7:4] != 4'h0) begin
                  uart.uart_wr_data <= RSP_ERR;
                  err_count         <= sat_inc(err_count);
               end else if (op_wr) begin
                  regs[{addr[3:0], 3'b000} +: 8] <= data;
                  uart.uart_wr_data              <= RSP_OK;
               end else begin
                  uart.uart_wr_data <= regs[{addr[3:0], 3'b000} +: 8];
               end
            end

            SEND: begin
               if (uart.uart_wr_ready) begin
                  uart.uart_wr_valid <= 1'b0;
                  uart.uart_rd_ready <= 1'b1;
                  state              <= IDLE;
               end
            end

            default: begin
               uart.uart_rd_ready <= 1'b0;
               uart.uart_wr_valid <= 1'b0;
               state              <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: protocol, errors, backpressure, timeout,
// asynchronous reset mid-frame and error-count saturation.
module tb_uart_cmd_responder;

   localparam logic [127:0] RV = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] regs;
   logic [7:0]   err_count;
   logic [127:0] exp_regs;
   int           checks = 0;
   int           errors = 0;
   int           stable_bad;

   uart_cmd_responder_if u_if ();

   uart_cmd_responder #(
      .TIMEOUT_CYCLES (20),
      .RESET_VALUE    (RV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart      (u_if),
      .regs      (regs),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a byte from just after a falling edge; return just after the edge that took it.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      u_if.uart_rd_data  = b;
      u_if.uart_rd_valid = 1'b1;
      while (u_if.uart_rd_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("rd_ready_wait", 128'(u_if.uart_rd_ready), 128'(1'b1));
      @(negedge clk);
      u_if.uart_rd_valid = 1'b0;
   endtask

   // Called right after the final frame byte is taken, with uart_wr_ready high.
   task automatic expect_resp(input string tag, input logic [7:0] exp);
      chk({tag, "_lat0"}, 128'(u_if.uart_wr_valid), 128'(1'b0));
      @(negedge clk);
      chk({tag, "_valid"}, 128'(u_if.uart_wr_valid), 128'(1'b1));
      chk({tag, "_data"}, 128'(u_if.uart_wr_data), 128'(exp));
      chk({tag, "_rdy_low"}, 128'(u_if.uart_rd_ready), 128'(1'b0));
      @(negedge clk);
      chk({tag, "_done"}, 128'(u_if.uart_wr_valid), 128'(1'b0));
      chk({tag, "_rdy_back"}, 128'(u_if.uart_rd_ready), 128'(1'b1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.uart_rd_data  = 8'h00;
      u_if.uart_rd_valid = 1'b0;
      u_if.uart_wr_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset values and ready rising on the first edge after release
      chk("rst_rd_ready", 128'(u_if.uart_rd_ready), 128'(1'b0));
      chk("rst_wr_valid", 128'(u_if.uart_wr_valid), 128'(1'b0));
      chk("rst_wr_data", 128'(u_if.uart_wr_data), 128'(8'h00));
      chk("rst_regs", regs, RV);
      chk("rst_err", 128'(err_count), 128'(8'h00));
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_rd_ready", 128'(u_if.uart_rd_ready), 128'(1'b1));
      exp_regs = RV;

      // Write then read back
      send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
      expect_resp("wr3", 8'h4B);
      exp_regs[31:24] = 8'hA5;
      chk("wr3_regs", regs, exp_regs);
      chk("wr3_err", 128'(err_count), 128'(8'h00));
      send_byte(8'h52); send_byte(8'h03);
      expect_resp("rd3", 8'hA5);

      // Unknown opcode and out-of-range address
      send_byte(8'h41);
      expect_resp("badop", 8'h3F);
      chk("badop_err", 128'(err_count), 128'(8'h01));
      send_byte(8'h57); send_byte(8'h10); send_byte(8'h55);
      expect_resp("badaddr", 8'h3F);
      chk("badaddr_regs", regs, exp_regs);
      chk("badaddr_err", 128'(err_count), 128'(8'h02));

      // Backpressure with the next frame's opcode already waiting upstream
      u_if.uart_wr_ready = 1'b0;
      send_byte(8'h52); send_byte(8'h05);
      chk("bp_lat0", 128'(u_if.uart_wr_valid), 128'(1'b0));
      u_if.uart_rd_data  = 8'h52;
      u_if.uart_rd_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", 128'(u_if.uart_wr_valid), 128'(1'b1));
      chk("bp_data", 128'(u_if.uart_wr_data), 128'(8'h5A));
      stable_bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (u_if.uart_wr_valid !== 1'b1 || u_if.uart_wr_data !== 8'h5A ||
             u_if.uart_rd_ready !== 1'b0) stable_bad++;
      end
      chk("bp_stable", 128'(stable_bad), 128'(0));
      u_if.uart_wr_ready = 1'b1;
      @(negedge clk);
      chk("bp_xfer_valid", 128'(u_if.uart_wr_valid), 128'(1'b0));
      chk("bp_xfer_rdy", 128'(u_if.uart_rd_ready), 128'(1'b1));
      @(negedge clk);
      u_if.uart_rd_valid = 1'b0;
      send_byte(8'h00);
      expect_resp("bp_next", 8'h0F);

      // Fresh reset, then inter-byte timeout
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_err", 128'(err_count), 128'(8'h00));
      rst_n = 1'b1;
      @(negedge clk);
      send_byte(8'h52);
      stable_bad = 0;
      repeat (25) begin
         @(negedge clk);
         if (u_if.uart_wr_valid !== 1'b0) stable_bad++;
      end
      chk("to_no_resp", 128'(stable_bad), 128'(0));
      chk("to_err", 128'(err_count), 128'(8'h01));
      chk("to_rdy", 128'(u_if.uart_rd_ready), 128'(1'b1));
      send_byte(8'h52); send_byte(8'h00);
      expect_resp("to_next", 8'h0F);
      chk("to_next_err", 128'(err_count), 128'(8'h01));

      // Byte arriving on the very edge the timeout would fire
      send_byte(8'h52);
      repeat (19) @(negedge clk);
      chk("edge_pre_err", 128'(err_count), 128'(8'h01));
      send_byte(8'h03);
      expect_resp("edge", 8'h3C);
      chk("edge_err", 128'(err_count), 128'(8'h01));

      // Asynchronous reset in the middle of a write frame
      send_byte(8'h57); send_byte(8'h02); send_byte(8'h77);
      expect_resp("wr2", 8'h4B);
      exp_regs = RV;
      exp_regs[23:16] = 8'h77;
      chk("wr2_regs", regs, exp_regs);
      send_byte(8'h57); send_byte(8'h05);
      #2;
      rst_n = 1'b0;
      #1;
      chk("amid_rd_ready", 128'(u_if.uart_rd_ready), 128'(1'b0));
      chk("amid_wr_valid", 128'(u_if.uart_wr_valid), 128'(1'b0));
      chk("amid_wr_data", 128'(u_if.uart_wr_data), 128'(8'h00));
      chk("amid_regs", regs, RV);
      chk("amid_err", 128'(err_count), 128'(8'h00));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      stable_bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (u_if.uart_wr_valid !== 1'b0) stable_bad++;
      end
      chk("amid_no_resp", 128'(stable_bad), 128'(0));
      chk("amid_regs_after", regs, RV);
      chk("amid_rdy_after", 128'(u_if.uart_rd_ready), 128'(1'b1));

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         send_byte(8'h41);
         @(negedge clk);
         @(negedge clk);
         if (i == 253) chk("sat_254", 128'(err_count), 128'(8'hFE));
         if (i == 254) chk("sat_255", 128'(err_count), 128'(8'hFF));
      end
      chk("sat_300", 128'(err_count), 128'(8'hFF));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
